// File: rtl/frame_ram_writer.sv
// frame_ram_writer: streams 8-bit pixels from a valid/ready source into a
// rectangular window of the frame RAM write port, row by row, one frame per
// start pulse. Optional byte-sum checksum enabled by FRAME_WRITER_CHECKSUM_EN.
module frame_ram_writer #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIM_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  input  logic [DIM_W-1:0]  stride,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] wraddress,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  output logic              busy,
  output logic              done,
  output logic [15:0]       checksum
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [DIM_W-1:0]  width_q;
  logic [DIM_W-1:0]  height_q;
  logic [DIM_W-1:0]  stride_q;
  logic [DIM_W-1:0]  col;
  logic [DIM_W-1:0]  row;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] row_addr;
  logic              accept;
  logic              start_ok;
  logic              zero_size;
  logic              last_col;
  logic              last_row;
  logic [ADDR_W-1:0] next_row_addr;

  // Handshake and frame-position decode
  assign in_ready      = (state == S_LOAD);
  assign accept        = in_valid && in_ready;
  assign start_ok      = start && (state == S_IDLE);
  assign zero_size     = (width == '0) || (height == '0);
  assign last_col      = (col == width_q - DIM_W'(1));
  assign last_row      = (row == height_q - DIM_W'(1));
  assign next_row_addr = row_addr + ADDR_W'(stride_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = zero_size ? S_DONE : S_LOAD;
      S_LOAD:  if (accept && last_col && last_row) state_next = S_FLUSH;
      S_FLUSH: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Registered status outputs follow the upcoming state
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next == S_LOAD) || (state_next == S_FLUSH);
      done <= (state_next == S_DONE);
    end
  end

  // Frame geometry latch and row/column address walker
  always_ff @(posedge clk) begin
    if (rst) begin
      width_q  <= '0;
      height_q <= '0;
      stride_q <= '0;
      col      <= '0;
      row      <= '0;
      cur_addr <= '0;
      row_addr <= '0;
    end else if (start_ok) begin
      width_q  <= width;
      height_q <= height;
      stride_q <= stride;
      col      <= '0;
      row      <= '0;
      cur_addr <= base_addr;
      row_addr <= base_addr;
    end else if (accept) begin
      if (last_col) begin
        col      <= '0;
        row      <= row + DIM_W'(1);
        row_addr <= next_row_addr;
        cur_addr <= next_row_addr;
      end else begin
        col      <= col + DIM_W'(1);
        cur_addr <= cur_addr + ADDR_W'(1);
      end
    end
  end

  // RAM write port, one cycle behind the accepted beat
  always_ff @(posedge clk) begin
    if (rst) begin
      wren      <= 1'b0;
      wraddress <= '0;
      data      <= '0;
    end else begin
      wren <= accept;
      if (accept) begin
        wraddress <= cur_addr;
        data      <= in_data;
      end
    end
  end

`ifdef FRAME_WRITER_CHECKSUM_EN
  logic [15:0] acc;

  // Byte-sum accumulator; published when the frame completes
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      checksum <= '0;
    end else begin
      if (start_ok)    acc <= '0;
      else if (accept) acc <= acc + 16'(in_data);
      if (state == S_DONE) checksum <= acc;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_frame_ram_writer.sv
// Scoreboard bench for frame_ram_writer: a driver streams random frames and
// pushes expected writes/done pulses; a monitor pops and compares.
module tb_frame_ram_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [17:0] base_addr = '0;
  logic [9:0]  width = '0;
  logic [9:0]  height = '0;
  logic [9:0]  stride = '0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [17:0] wraddress;
  logic [7:0]  data;
  logic        wren;
  logic        busy;
  logic        done;
  logic [15:0] checksum;

  typedef struct {
    logic [17:0] addr;
    logic [7:0]  d;
    int unsigned cyc;
  } wr_t;

  wr_t         wq[$];
  int unsigned dq[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          done_count = 0;

  frame_ram_writer dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .width(width), .height(height), .stride(stride),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wraddress(wraddress), .data(data), .wren(wren),
    .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every write and done pulse must match the head of its queue
  always @(negedge clk) begin
    if (wren) begin
      if (wq.size() == 0) chk("unexpected_wren", 32'(wraddress), 32'hFFFF_FFFF);
      else begin
        wr_t e;
        e = wq.pop_front();
        chk("wr_addr", 32'(wraddress), 32'(e.addr));
        chk("wr_data", 32'(data), 32'(e.d));
        chk("wr_cycle", cyc, e.cyc);
      end
    end
    if (done) begin
      done_count++;
      if (dq.size() == 0) chk("unexpected_done", cyc, 32'hFFFF_FFFF);
      else chk("done_cycle", cyc, dq.pop_front());
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_wren"}, 32'(wren), 0);
    chk({tag, "_wraddress"}, 32'(wraddress), 0);
    chk({tag, "_data"}, 32'(data), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_checksum"}, 32'(checksum), 0);
  endtask

  // vmode: 0 = valid held high, 1 = toggle 1,0,1,0, 2 = random
  task automatic run_frame(input logic [17:0] b, input int w, input int h, input int s,
                           input int vmode, input bit poke_start, input int rst_after);
    int n;
    int k;
    int budget;
    int sum;
    int dc0;
    bit v;
    bit toggle;
    logic [17:0] a;
    n = w * h;
    k = 0;
    sum = 0;
    toggle = 1'b1;
    @(negedge clk);
    base_addr = b; width = 10'(w); height = 10'(h); stride = 10'(s); start = 1'b1;
    dc0 = done_count;
    if (n == 0) dq.push_back(cyc + 1);
    @(negedge clk);
    start = 1'b0;
    base_addr = 18'($urandom); width = 10'($urandom); height = 10'($urandom);
    stride = 10'($urandom);
    if (n == 0) begin
      chk("zero_in_ready", 32'(in_ready), 0);
      chk("zero_busy", 32'(busy), 0);
    end else begin
      budget = 0;
      while (k < n && budget < 4000) begin
        if (vmode == 0) v = 1'b1;
        else if (vmode == 1) v = toggle;
        else v = ($urandom_range(0, 3) != 0);
        toggle = !toggle;
        in_valid = v;
        in_data = 8'($urandom);
        start = poke_start && (k == 2);
        if (v && in_ready) begin
          a = b + 18'((k / w) * s + (k % w));
          wq.push_back('{a, in_data, cyc + 1});
          sum += int'(in_data);
          k++;
          if (k == n) dq.push_back(cyc + 2);
        end
        @(negedge clk);
        budget++;
        if (rst_after > 0 && k == rst_after) begin
          in_valid = 1'b0;
          start = 1'b0;
          rst = 1'b1;
          @(negedge clk);
          check_reset_outputs("midrst");
          rst = 1'b0;
          repeat (12) @(negedge clk);
          #1;
          chk("midrst_no_done", 32'(done_count), 32'(dc0));
          chk("midrst_writes_drained", 32'(wq.size()), 0);
          return;
        end
      end
      in_valid = 1'b0;
      start = 1'b0;
      chk("frame_beats", 32'(k), 32'(n));
      chk("flush_in_ready", 32'(in_ready), 0);
      chk("flush_busy", 32'(busy), 1);
    end
    for (int i = 0; i < 10; i++) begin
      #1;
      if (done_count > dc0) break;
      @(negedge clk);
    end
    chk("done_seen", 32'(done_count > dc0), 1);
    @(negedge clk);
`ifdef FRAME_WRITER_CHECKSUM_EN
    chk("checksum", 32'(checksum), 32'(16'(sum)));
`else
    chk("checksum", 32'(checksum), 0);
`endif
    chk("idle_busy", 32'(busy), 0);
    chk("idle_in_ready", 32'(in_ready), 0);
    repeat (2) @(negedge clk);
    #1;
    chk("done_once", 32'(done_count), 32'(dc0 + 1));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    // Basic frame, held valid
    run_frame(18'h00100, 4, 2, 640, 0, 1'b0, 0);
    // Bubbles
    run_frame(18'h00100, 4, 2, 640, 1, 1'b0, 0);
    // Wrap-around
    run_frame(18'h3FFFE, 4, 1, 7, 0, 1'b0, 0);
    // Zero size, both dimensions
    run_frame(18'h01234, 0, 5, 100, 0, 1'b0, 0);
    run_frame(18'h01234, 3, 0, 100, 0, 1'b0, 0);
    // Start pulse mid-load is ignored
    run_frame(18'h02000, 4, 3, 20, 0, 1'b1, 0);
    // Overlapping rows (stride < width)
    run_frame(18'h00010, 4, 3, 2, 2, 1'b0, 0);
    // Reset mid-transfer after 3 of 8 beats
    run_frame(18'h00100, 4, 2, 640, 0, 1'b0, 3);
    // Randomized frames
    for (int f = 0; f < 8; f++)
      run_frame(18'($urandom), int'($urandom_range(1, 8)), int'($urandom_range(1, 5)),
                int'($urandom_range(0, 1023)), 2, f[0], 0);
    // Single-pixel frame at the top of the address space
    run_frame(18'h3FFFF, 1, 1, 1023, 0, 1'b0, 0);
    repeat (3) @(negedge clk);
    chk("wq_empty", 32'(wq.size()), 0);
    chk("dq_empty", 32'(dq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
